state_event_logger: RTL and testbench

STATE_EVENT_LOGGER -- requirements
Module: state_event_logger

---
 rtl/state_event_logger_pkg.sv | 28 ++
 rtl/state_event_logger_event_fifo.sv | 92 +++++++++
 rtl/state_event_logger.sv | 100 ++++++++++
 tb/tb_state_event_logger.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/state_event_logger_pkg.sv
// -----------------------------------------------------------------------------
// state_event_logger_pkg
// Shared definitions for the state-change event logger:
//   - default FIFO depth and timestamp width
//   - event record layout {state, flag, time_stamp} at the default width
//   - overflow counter saturation value and saturating increment helper
// No ports (package).
// -----------------------------------------------------------------------------
package state_event_logger_pkg;

   localparam int DEF_DEPTH    = 8;
   localparam int DEF_TS_WIDTH = 16;

   localparam logic [7:0] OVF_SAT = 8'hFF;

   // Record layout as stored in the FIFO, MSB first.
   typedef struct packed {
      logic [7:0]              state;
      logic                    flag;
      logic [DEF_TS_WIDTH-1:0] time_stamp;
   } evt_rec_t;

   // Increment that sticks at OVF_SAT instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == OVF_SAT) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/state_event_logger_event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Synchronous first-word-fall-through FIFO with a registered valid flag.
// A push is accepted when the FIFO is not full, or when it is full and a pop
// happens in the same cycle (the freed slot is reused). A push that cannot be
// accepted is reported on 'drop' and leaves the contents unchanged.
// While empty the output payload reads as zero.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (empties the FIFO)
//   push       in   write request
//   push_data  in   WIDTH  record to write
//   drop       out  push requested while full with no pop
//   pop_ready  in   consumer ready; pop occurs on out_valid & pop_ready
//   out_valid  out  head record available
//   out_data   out  WIDTH  head record (zero when empty)
//   level      out  clog2(DEPTH)+1  number of stored records
// -----------------------------------------------------------------------------
module event_fifo
   import state_event_logger_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = 9 + DEF_TS_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     drop,
   input  logic                     pop_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             valid_q;
   logic             full;
   logic             pop;
   logic             wr_en;

   assign full  = (count == FULL_CNT);
   assign pop   = valid_q & pop_ready;
   // When full, a simultaneous pop frees the head slot, so the push still fits.
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would infer a latch.
      count_nxt = count;
      unique case ({wr_en, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         count   <= count_nxt;
         valid_q <= (count_nxt != '0);
      end
   end

   // NOTE: the storage array has no reset; its contents are only observable
   // through out_data, which is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_ptr] <= push_data;
   end

   assign out_valid = valid_q;
   assign out_data  = valid_q ? mem[rd_ptr] : '0;
   assign level     = count;

endmodule

// File: rtl/state_event_logger.sv
// -----------------------------------------------------------------------------
// state_event_logger
// Watches an upstream FSM state code and flag, and logs every change as a
// timestamped record into a small FIFO drained through a valid/ready stream.
// Records that arrive while the FIFO is full are dropped and counted.
// Ports:
//   clk              in   clock
//   reset            in   synchronous active-high reset
//   io_state         in   8         upstream state code
//   io_flag          in   1         upstream flag
//   io_enable        in   1         logging enable (suppresses pushes only)
//   io_clear         in   1         zero the overflow counter
//   io_evt_valid     out  1         record available
//   io_evt_ready     in   1         consumer accepts record
//   io_evt_state     out  8         logged state
//   io_evt_flag      out  1         logged flag
//   io_evt_time      out  TS_WIDTH  timestamp of the change
//   io_level         out  clog2(DEPTH)+1  FIFO occupancy
//   io_overflow_cnt  out  8         dropped-record count (saturating)
// -----------------------------------------------------------------------------
module state_event_logger
   import state_event_logger_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int TS_WIDTH = DEF_TS_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               io_state,
   input  logic                     io_flag,
   input  logic                     io_enable,
   input  logic                     io_clear,
   output logic                     io_evt_valid,
   input  logic                     io_evt_ready,
   output logic [7:0]               io_evt_state,
   output logic                     io_evt_flag,
   output logic [TS_WIDTH-1:0]      io_evt_time,
   output logic [$clog2(DEPTH):0]   io_level,
   output logic [7:0]               io_overflow_cnt
);

   localparam int REC_W = 8 + 1 + TS_WIDTH;

   logic [TS_WIDTH-1:0] ts_cnt;
   logic [7:0]          prev_state;
   logic                prev_flag;
   logic [7:0]          ovf_cnt;
   logic                change_evt;
   logic                fifo_drop;
   logic [REC_W-1:0]    push_rec;
   logic [REC_W-1:0]    head_rec;

   // Free-running timestamp; wraps naturally at 2^TS_WIDTH.
   always_ff @(posedge clk) begin
      if (reset) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + 1'b1;
   end

   // Previous-input registers track the inputs every cycle, even when logging
   // is disabled, so re-enabling never reports a stale difference.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_state <= 8'h00;
         prev_flag  <= 1'b0;
      end else begin
         prev_state <= io_state;
         prev_flag  <= io_flag;
      end
   end

   assign change_evt = io_enable & ({io_state, io_flag} != {prev_state, prev_flag});
   assign push_rec   = {io_state, io_flag, ts_cnt};

   // The FIFO's own reset wins over a push on the reset edge.
   event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (change_evt),
      .push_data (push_rec),
      .drop      (fifo_drop),
      .pop_ready (io_evt_ready),
      .out_valid (io_evt_valid),
      .out_data  (head_rec),
      .level     (io_level)
   );

   // Clear has priority over a drop in the same cycle.
   always_ff @(posedge clk) begin
      if (reset)          ovf_cnt <= 8'h00;
      else if (io_clear)  ovf_cnt <= 8'h00;
      else if (fifo_drop) ovf_cnt <= sat_inc(ovf_cnt);
   end

   assign {io_evt_state, io_evt_flag, io_evt_time} = head_rec;
   assign io_overflow_cnt = ovf_cnt;

endmodule

// File: tb/tb_state_event_logger.sv
// -----------------------------------------------------------------------------
// tb_state_event_logger
// Directed stimulus with a scoreboard queue: the stimulus side pushes the
// record it expects the logger to emit; a monitor pops and compares on every
// valid&ready transfer.
// -----------------------------------------------------------------------------
module tb_state_event_logger;
   import state_event_logger_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  io_state;
   logic        io_flag;
   logic        io_enable;
   logic        io_clear;
   logic        io_evt_valid;
   logic        io_evt_ready;
   logic [7:0]  io_evt_state;
   logic        io_evt_flag;
   logic [15:0] io_evt_time;
   logic [3:0]  io_level;
   logic [7:0]  io_overflow_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   logic [15:0] cyc = '0;
   evt_rec_t sb_q[$];

   always #5 clk = ~clk;

   state_event_logger dut (
      .clk             (clk),
      .reset           (reset),
      .io_state        (io_state),
      .io_flag         (io_flag),
      .io_enable       (io_enable),
      .io_clear        (io_clear),
      .io_evt_valid    (io_evt_valid),
      .io_evt_ready    (io_evt_ready),
      .io_evt_state    (io_evt_state),
      .io_evt_flag     (io_evt_flag),
      .io_evt_time     (io_evt_time),
      .io_level        (io_level),
      .io_overflow_cnt (io_overflow_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Advance one cycle; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      sb_q.delete();
      reset = 1'b1;
      for (int i = 0; i < n; i++) tick();
      reset = 1'b0;
      cyc   = '0;
   endtask

   // Present a new input this cycle; exp_push says whether a record is expected
   // to be stored (hand-decided per vector).
   task automatic change(input logic [7:0] st, input logic fl, input logic exp_push);
      evt_rec_t r;
      io_state = st;
      io_flag  = fl;
      if (exp_push) begin
         r.state      = st;
         r.flag       = fl;
         r.time_stamp = cyc;
         sb_q.push_back(r);
      end
      tick();
   endtask

   task automatic drain(input string name, input int n);
      int p0;
      int k;
      p0 = n_pops;
      k  = 0;
      io_evt_ready = 1'b1;
      while (io_level != 0 && k < 100) begin
         tick();
         k++;
      end
      io_evt_ready = 1'b0;
      check({name, "_level"}, 32'(io_level), 32'd0);
      check({name, "_pops"}, 32'(n_pops - p0), 32'(n));
      check({name, "_valid_after"}, 32'(io_evt_valid), 32'd0);
   endtask

   // Monitor: compare every transfer against the scoreboard head.
   always @(negedge clk) begin
      evt_rec_t e;
      if (!reset && io_evt_valid && io_evt_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_record actual=%0h expected=none",
                     {io_evt_state, io_evt_flag, io_evt_time});
         end else begin
            e = sb_q.pop_front();
            check("record", 32'({io_evt_state, io_evt_flag, io_evt_time}), 32'(e));
            n_pops++;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      io_state     = 8'h00;
      io_flag      = 1'b0;
      io_enable    = 1'b1;
      io_clear     = 1'b0;
      io_evt_ready = 1'b0;
      do_reset(2);

      // Reset state.
      check("rst_valid", 32'(io_evt_valid), 32'd0);
      check("rst_level", 32'(io_level), 32'd0);
      check("rst_ovf",   32'(io_overflow_cnt), 32'd0);
      check("rst_state", 32'(io_evt_state), 32'd0);
      check("rst_flag",  32'(io_evt_flag), 32'd0);
      check("rst_time",  32'(io_evt_time), 32'd0);

      // Single change at cycle 10, valid in cycle 11.
      for (int i = 0; i < 10; i++) tick();
      change(8'h01, 1'b0, 1'b1);
      check("first_valid", 32'(io_evt_valid), 32'd1);
      check("first_level", 32'(io_level), 32'd1);
      check("first_state", 32'(io_evt_state), 32'h01);
      check("first_time",  32'(io_evt_time), 32'd10);
      drain("first", 1);

      // Ten changes with ready low: eight stored, two dropped.
      for (int i = 0; i < 10; i++) change(8'h10 + 8'(i), 1'b0, i < 8);
      tick();
      tick();
      check("fill_level", 32'(io_level), 32'd8);
      check("fill_ovf",   32'(io_overflow_cnt), 32'd2);
      check("hold_state", 32'(io_evt_state), 32'h10);
      check("hold_valid", 32'(io_evt_valid), 32'd1);
      drain("fill", 8);

      // Full FIFO, push and pop in the same cycle.
      for (int i = 0; i < 8; i++) change(8'h20 + 8'(i), 1'b1, 1'b1);
      check("full_level", 32'(io_level), 32'd8);
      io_evt_ready = 1'b1;
      change(8'h28, 1'b0, 1'b1);
      io_evt_ready = 1'b0;
      check("pp_level", 32'(io_level), 32'd8);
      check("pp_ovf",   32'(io_overflow_cnt), 32'd2);
      drain("pp", 8);

      // Disabled logging and stable input produce nothing.
      io_enable = 1'b0;
      change(8'h02, 1'b0, 1'b0);
      change(8'h03, 1'b0, 1'b0);
      change(8'h03, 1'b1, 1'b0);
      io_enable = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("dis_level", 32'(io_level), 32'd0);
      check("dis_valid", 32'(io_evt_valid), 32'd0);

      // Timestamp wrap.
      for (int g = 0; g < 70000 && cyc != 16'hFFFF; g++) tick();
      change(8'h40, 1'b0, 1'b1);
      check("wrap_time_hi", 32'(io_evt_time), 32'h0000_FFFF);
      change(8'h41, 1'b0, 1'b1);
      check("wrap_level", 32'(io_level), 32'd2);
      drain("wrap", 2);

      // Overflow saturation and clear priority.
      io_clear = 1'b1;
      tick();
      io_clear = 1'b0;
      check("clr_ovf", 32'(io_overflow_cnt), 32'd0);
      for (int i = 0; i < 8; i++) change(8'h60 + 8'(i), 1'b0, 1'b1);
      for (int i = 0; i < 260; i++) change(i[0] ? 8'h68 : 8'h69, 1'b0, 1'b0);
      check("sat_ovf",   32'(io_overflow_cnt), 32'd255);
      check("sat_level", 32'(io_level), 32'd8);
      io_clear = 1'b1;
      change(8'h6A, 1'b0, 1'b0);
      io_clear = 1'b0;
      check("clr_drop_ovf",   32'(io_overflow_cnt), 32'd0);
      check("clr_drop_level", 32'(io_level), 32'd8);
      drain("sat", 8);

      // Reset with three queued records and a change on the reset edge.
      for (int i = 0; i < 3; i++) change(8'h70 + 8'(i), 1'b0, 1'b1);
      check("q3_level", 32'(io_level), 32'd3);
      io_state = 8'h73;
      do_reset(1);
      check("mid_rst_level", 32'(io_level), 32'd0);
      check("mid_rst_valid", 32'(io_evt_valid), 32'd0);
      check("mid_rst_state", 32'(io_evt_state), 32'd0);
      check("mid_rst_time",  32'(io_evt_time), 32'd0);
      io_enable = 1'b0;

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
